// File: rtl/shift_reg_sipo_rx_pkg.sv
// Shared definitions for the serial-in parallel-out frame receiver:
// default payload width, receiver FSM states and serial line levels.
package shift_reg_sipo_rx_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  // Serial line levels; the line idles at the stop level.
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage : shift_reg_sipo_rx_pkg

// File: rtl/sipo_shift_reg.sv
// Capture register for one frame payload; bits arrive LSB first, so each
// new bit enters at the MSB and the first bit ends up in q[0].
module sipo_shift_reg
  import shift_reg_sipo_rx_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {sdi, q[WIDTH-1:1]};
    end
  end

endmodule : sipo_shift_reg

// File: rtl/shift_reg_sipo_rx.sv
// Serial frame receiver: start(1), WIDTH data bits LSB first, stop(0).
// Presents each good payload through a valid/ready holding register.
module shift_reg_sipo_rx
  import shift_reg_sipo_rx_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdi,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             shift_en;
  logic             frame_done;
  logic [WIDTH-1:0] shift_q;

  logic             good_frame;
  logic             bad_frame;
  logic             handshake;
  logic             load;
  logic             drop;
  logic             valid_next;

  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .sdi      (sdi),
    .q        (shift_q)
  );

  // FSM state and bit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (sdi == START_BIT) begin
          state_next = DATA;
          count_next = '0;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (count == LAST_BIT) begin
          state_next = STOP;
          count_next = '0;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      STOP: begin
        // Always back to IDLE: a bad stop bit must not double as a start bit.
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // A completing frame may reuse a slot the consumer frees at the same edge.
  always_comb begin
    good_frame = frame_done && (sdi == STOP_BIT);
    bad_frame  = frame_done && (sdi != STOP_BIT);
    handshake  = data_valid && data_ready;
    load       = good_frame && (!data_valid || data_ready);
    drop       = good_frame && data_valid && !data_ready;
    valid_next = data_valid;
    if (load) begin
      valid_next = 1'b1;
    end else if (handshake) begin
      valid_next = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        data_out <= shift_q;
      end
      data_valid <= valid_next;
      frame_err  <= bad_frame;
      overrun    <= drop;
    end
  end

endmodule : shift_reg_sipo_rx

// File: tb/tb_shift_reg_sipo_rx.sv
// Scoreboard bench for shift_reg_sipo_rx: frame-level reference model feeds a
// queue of per-edge expectations that a negedge monitor compares.
module tb_shift_reg_sipo_rx;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         v;
    logic         fe;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         sdi;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic         frame_err;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  exp_t         exp_q[$];
  logic [W-1:0] m_data;
  logic         m_valid;

  shift_reg_sipo_rx #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sdi        (sdi),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; the model applies the frame-level rules for that edge.
  task automatic drive_cycle(input logic sdi_v, input logic rdy, input logic is_stop,
                             input logic [W-1:0] payload);
    exp_t e;
    logic hs;
    @(negedge clk);
    sdi        = sdi_v;
    data_ready = rdy;
    @(posedge clk);
    hs   = m_valid && rdy;
    e.fe = 1'b0;
    e.ov = 1'b0;
    if (is_stop && sdi_v == 1'b0) begin
      if (!m_valid || rdy) begin
        m_data  = payload;
        m_valid = 1'b1;
      end else begin
        e.ov = 1'b1;
      end
    end else begin
      if (is_stop) e.fe = 1'b1;
      if (hs) m_valid = 1'b0;
    end
    e.d = m_data;
    e.v = m_valid;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, rdy, 1'b0, '0);
  endtask

  task automatic send_frame(input logic [W-1:0] p, input logic stop_v, input logic rdy_body,
                            input logic rdy_stop, input logic rnd);
    drive_cycle(1'b1, rnd ? 1'($urandom_range(1)) : rdy_body, 1'b0, p);
    for (int i = 0; i < int'(W); i++)
      drive_cycle(p[i], rnd ? 1'($urandom_range(1)) : rdy_body, 1'b0, p);
    drive_cycle(stop_v, rnd ? 1'($urandom_range(1)) : rdy_stop, 1'b1, p);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".data_out"},   32'(data_out),   32'd0);
    chk({tag, ".data_valid"}, 32'(data_valid), 32'd0);
    chk({tag, ".frame_err"},  32'(frame_err),  32'd0);
    chk({tag, ".overrun"},    32'(overrun),    32'd0);
  endtask

  // Monitor: compares the outputs after every modelled edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data_out",   32'(data_out),   32'(e.d));
      chk("data_valid", 32'(data_valid), 32'(e.v));
      chk("frame_err",  32'(frame_err),  32'(e.fe));
      chk("overrun",    32'(overrun),    32'(e.ov));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] p;
    logic         sb;

    reset      = 1'b1;
    sdi        = 1'b0;
    data_ready = 1'b0;
    m_data     = '0;
    m_valid    = 1'b0;
    #2 reset = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Single frame, held, then consumed
    idle_cycles(2, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, 1'b1);

    // Back-to-back frames with the consumer always ready
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_cycles(2, 1'b1);

    // Overrun: second frame dropped while first is unread
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);
    idle_cycles(1, 1'b1);

    // Bad stop bit followed immediately by a good frame
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(1, 1'b1);

    // Handshake at the same edge the next frame completes
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(1, 1'b0);

    // Reset after the 4th data bit with an unread frame held
    p = 8'h6B;
    drive_cycle(1'b1, 1'b0, 1'b0, p);
    for (int i = 0; i < 4; i++) drive_cycle(p[i], 1'b0, 1'b0, p);
    @(negedge clk);
    #1;
    sdi   = 1'b0;
    reset = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_cycles(1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(1, 1'b1);

    // Randomised traffic with occasional bad stops and random gaps
    for (int f = 0; f < 150; f++) begin
      p  = W'($urandom);
      sb = ($urandom_range(7) == 0);
      send_frame(p, sb, 1'b0, 1'b0, 1'b1);
      idle_cycles(int'($urandom_range(2)), 1'($urandom_range(1)));
    end

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shift_reg_sipo_rx
